// File: rtl/inv_cipher.sv
// Iterative AES inverse cipher: one round per clock,
// key schedule expanded on-chip one word per clock.
module inv_cipher #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:Nk*32-1] key,
  input  logic             key_load,
  output logic             key_ready,
  input  logic [0:127]     in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [0:127]     out,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int NW = 4*Nr+4;
  localparam int IW = $clog2(NW);
  localparam int RW = $clog2(Nr+1);
  localparam int KW = $clog2(Nk);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse, and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]}
              ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]),
            sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  function automatic logic [0:127] inv_round(input logic [0:127] s,
                                             input logic [0:127] rk,
                                             input logic mix);
    logic [0:127] t;
    logic [0:127] u;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++)
        t[8*(4*c+k) +: 8] = inv_sbox(s[8*(4*((c+4-k)%4)+k) +: 8]);
    t = t ^ rk;
    u = t;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[32*c +: 8];
        a1 = t[32*c+8 +: 8];
        a2 = t[32*c+16 +: 8];
        a3 = t[32*c+24 +: 8];
        u[32*c +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                     ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        u[32*c+8 +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                       ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        u[32*c+16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                        ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        u[32*c+24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                        ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    return u;
  endfunction

  state_t        state;
  logic [31:0]   w [NW];
  logic [0:127]  st;
  logic [RW-1:0] rnd;
  logic [IW-1:0] idx;
  logic [KW-1:0] kc;
  logic [7:0]    rc;

  logic [31:0]   prev;
  logic [31:0]   f;
  logic [31:0]   wn;
  logic [IW-1:0] rb;
  logic [0:127]  rk_cur;
  logic [0:127]  rk_last;

  always_comb begin
    prev = w[idx - IW'(1)];
    if (kc == '0)
      f = sub_word({prev[23:0], prev[31:24]}) ^ {rc, 24'h0};
    else if (Nk > 6 && kc == KW'(4))
      f = sub_word(prev);
    else
      f = prev;
    wn = w[idx - IW'(Nk)] ^ f;
  end

  always_comb begin
    rb = IW'({rnd, 2'b00});
    rk_cur = {w[rb], w[rb + IW'(1)],
              w[rb + IW'(2)], w[rb + IW'(3)]};
    rk_last = {w[NW-4], w[NW-3], w[NW-2], w[NW-1]};
  end

  assign in_ready = (state == IDLE) && key_ready && !key_load;
  assign out = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_ready <= 1'b0;
      out_valid <= 1'b0;
      st        <= '0;
      rnd       <= '0;
      idx       <= '0;
      kc        <= '0;
      rc        <= 8'h01;
      for (int j = 0; j < NW; j++) w[j] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (key_load) begin
            for (int j = 0; j < Nk; j++) w[j] <= key[32*j +: 32];
            key_ready <= 1'b0;
            idx       <= IW'(Nk);
            kc        <= '0;
            rc        <= 8'h01;
            state     <= KEYEXP;
          end else if (in_valid && key_ready) begin
            st    <= in ^ rk_last;
            rnd   <= RW'(Nr-1);
            state <= ROUND;
          end
        end
        KEYEXP: begin
          w[idx] <= wn;
          if (kc == '0) rc <= xt(rc);
          kc  <= (kc == KW'(Nk-1)) ? '0 : kc + KW'(1);
          idx <= idx + IW'(1);
          if (idx == IW'(NW-1)) begin
            key_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        ROUND: begin
          st <= inv_round(st, rk_cur, rnd != '0);
          if (rnd == '0) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rnd <= rnd - RW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
